fpu_vector_checker: RTL

Synthesizable test sequencer and checker for the fpu datapath. Fetches packed vectors from a synchronous vector memory, drives funct/a/b into the DUT, waits for finish with a timeout, and compares the result against the expected value using a configurable ULP tolerance. Counts vectors and errors for on-chip or FPGA regression, where a simulation testbench is not available.

---
 rtl/fpu_vector_checker.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_vector_checker.sv
//==============================================================================
// Module      : fpu_vector_checker
// Description : Self-contained test sequencer and checker for the fpu datapath.
//               Walks a synchronous vector memory, drives each vector's
//               funct/a/b into the fpu, waits for a finish rising edge (with a
//               timeout), and compares the result to the expected value using
//               an ordered-integer ULP tolerance. Counts vectors and errors so
//               a regression can run on-chip without a simulation testbench.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   start          in   1      pulse; begins a run at address 0 (only in idle)
//   vec_addr       out  AW     vector memory read address
//   vec_rd         out  1      read strobe; vec_data valid one cycle later
//   vec_data       in   3W+4   {valid, last, funct[1:0], a, b, exp}
//   dut_funct      out  2      fpu operation select
//   dut_a, dut_b   out  W      fpu operands, held until the vector completes
//   dut_go         out  1      one-cycle start pulse to the fpu
//   dut_o          in   W      fpu result
//   dut_finish     in   1      fpu completion (rising edge is used)
//   busy           out  1      run in progress
//   done           out  1      run finished; cleared by the next start
//   mismatch       out  1      one-cycle pulse per failed vector
//   timeout_err    out  1      sticky: a vector timed out during this run
//   vec_count      out  AW+1   vectors checked this run
//   err_count      out  AW+1   failed vectors this run (saturating)
//   first_err_idx  out  AW     index of the first failing vector
//==============================================================================
`default_nettype none

module fpu_vector_checker #(
    parameter int W       = 32,
    parameter int EXP_W   = 8,
    parameter int DEPTH   = 1024,
    parameter int TOL_ULP = 2,
    parameter int TIMEOUT = 4095,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [AW-1:0]    vec_addr,
    output logic             vec_rd,
    input  logic [3*W+3:0]   vec_data,
    output logic [1:0]       dut_funct,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    output logic             dut_go,
    input  logic [W-1:0]     dut_o,
    input  logic             dut_finish,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic             timeout_err,
    output logic [AW:0]      vec_count,
    output logic [AW:0]      err_count,
    output logic [AW-1:0]    first_err_idx
);

    localparam int VW     = 3 * W + 4;
    localparam int FRAC_W = W - 1 - EXP_W;
    localparam int TCW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_CHECK = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [AW-1:0]   r_addr;
    logic            r_last;
    logic [1:0]      r_funct;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_exp;
    logic [W-1:0]    r_result;
    logic            r_fin_q;
    logic [TCW-1:0]  r_tcnt;
    logic            r_done;
    logic            r_tmo;
    logic [AW:0]     r_vec_cnt;
    logic [AW:0]     r_err_cnt;
    logic [AW-1:0]   r_first;

    logic            w_fin_rise;
    logic            w_tmo_hit;
    logic            w_stop;
    logic            w_err_event;
    logic            w_pass;

    //--------------------------------------------------------------------------
    // Result comparison on the captured result and expected value
    //--------------------------------------------------------------------------
    logic              w_nan_o, w_nan_e, w_inf_o, w_inf_e, w_zero_o, w_zero_e;
    logic [W-1:0]      w_ord_o, w_ord_e;
    logic [W:0]        w_diff;

    assign w_nan_o  = (&r_result[W-2 -: EXP_W]) && (|r_result[FRAC_W-1:0]);
    assign w_nan_e  = (&r_exp[W-2 -: EXP_W])    && (|r_exp[FRAC_W-1:0]);
    assign w_inf_o  = (&r_result[W-2 -: EXP_W]) && !(|r_result[FRAC_W-1:0]);
    assign w_inf_e  = (&r_exp[W-2 -: EXP_W])    && !(|r_exp[FRAC_W-1:0]);
    assign w_zero_o = !(|r_result[W-2:0]);
    assign w_zero_e = !(|r_exp[W-2:0]);

    // Monotonic mapping of sign-magnitude floats onto unsigned integers, so
    // the distance between two values is the number of representable steps.
    assign w_ord_o = r_result[W-1] ? ~r_result : (r_result | {1'b1, {(W-1){1'b0}}});
    assign w_ord_e = r_exp[W-1]    ? ~r_exp    : (r_exp    | {1'b1, {(W-1){1'b0}}});
    assign w_diff  = (w_ord_o >= w_ord_e) ? {1'b0, w_ord_o - w_ord_e}
                                          : {1'b0, w_ord_e - w_ord_o};

    // NaN is decided first; Inf vs finite must fail even when the ordered
    // distance is tiny (max finite sits one step below Inf); the two zeros
    // are one step apart in ordered space but must always compare equal.
    always_comb begin
        w_pass = 1'b0;
        if (w_nan_o || w_nan_e) begin
            w_pass = w_nan_o && w_nan_e;
        end else if (w_inf_o != w_inf_e) begin
            w_pass = 1'b0;
        end else if (w_zero_o && w_zero_e) begin
            w_pass = 1'b1;
        end else begin
            w_pass = (w_diff <= (W+1)'(TOL_ULP));
        end
    end

    //--------------------------------------------------------------------------
    // Control
    //--------------------------------------------------------------------------
    assign w_fin_rise = dut_finish && !r_fin_q;
    assign w_tmo_hit  = (r_state == S_WAIT) && !w_fin_rise && (r_tcnt == TCW'(TIMEOUT));
    assign w_stop     = r_last || (r_addr == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        vec_rd       = 1'b0;
        dut_go       = 1'b0;
        busy         = 1'b1;
        mismatch     = 1'b0;
        w_err_event  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                vec_rd       = 1'b1;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = vec_data[VW-1] ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                dut_go       = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_fin_rise) begin
                    w_state_next = S_CHECK;
                end else if (w_tmo_hit) begin
                    mismatch     = 1'b1;
                    w_err_event  = 1'b1;
                    w_state_next = S_NEXT;
                end
            end
            S_CHECK: begin
                if (!w_pass) begin
                    mismatch    = 1'b1;
                    w_err_event = 1'b1;
                end
                w_state_next = S_NEXT;
            end
            S_NEXT: begin
                w_state_next = w_stop ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and run statistics
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_last    <= 1'b0;
            r_funct   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_exp     <= '0;
            r_result  <= '0;
            r_fin_q   <= 1'b0;
            r_tcnt    <= '0;
            r_done    <= 1'b0;
            r_tmo     <= 1'b0;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_first   <= '0;
        end else begin
            // Sampled every cycle so a finish level held across vectors
            // never looks like a new edge.
            r_fin_q <= dut_finish;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr    <= '0;
                        r_vec_cnt <= '0;
                        r_err_cnt <= '0;
                        r_done    <= 1'b0;
                        r_tmo     <= 1'b0;
                        r_first   <= '0;
                    end
                end
                S_LOAD: begin
                    r_last <= vec_data[VW-2];
                    if (vec_data[VW-1]) begin
                        r_funct <= vec_data[3*W+1:3*W];
                        r_a     <= vec_data[3*W-1:2*W];
                        r_b     <= vec_data[2*W-1:W];
                        r_exp   <= vec_data[W-1:0];
                    end
                end
                S_ISSUE: begin
                    r_tcnt <= '0;
                end
                S_WAIT: begin
                    if (w_fin_rise) begin
                        r_result <= dut_o;
                    end else if (w_tmo_hit) begin
                        r_tmo <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    r_vec_cnt <= r_vec_cnt + 1'b1;
                    if (!w_stop) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (w_err_event) begin
                if (!(&r_err_cnt)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (r_err_cnt == '0) begin
                    r_first <= r_addr;
                end
            end

            if (w_state_next == S_DONE) begin
                r_done <= 1'b1;
            end
        end
    end

    assign vec_addr      = r_addr;
    assign dut_funct     = r_funct;
    assign dut_a         = r_a;
    assign dut_b         = r_b;
    assign done          = r_done;
    assign timeout_err   = r_tmo;
    assign vec_count     = r_vec_cnt;
    assign err_count     = r_err_cnt;
    assign first_err_idx = r_first;

endmodule

`default_nettype wire
